rca_seq_adder: RTL and testbench



---
 rtl/rca_seq_adder.sv | 110 +++++++++++
 tb/tb_rca_seq_adder.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rca_seq_adder.sv
// rtl/rca_seq_adder.sv - nibble-serial add/subtract sequencer around one 4-bit ripple-carry adder
module rca (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic c1, c2, c3;

  assign sum[0] = a[0] ^ b[0] ^ cin;
  assign c1     = (a[0] & b[0]) | (a[0] & cin) | (b[0] & cin);
  assign sum[1] = a[1] ^ b[1] ^ c1;
  assign c2     = (a[1] & b[1]) | (a[1] & c1) | (b[1] & c1);
  assign sum[2] = a[2] ^ b[2] ^ c2;
  assign c3     = (a[2] & b[2]) | (a[2] & c2) | (b[2] & c2);
  assign sum[3] = a[3] ^ b[3] ^ c3;
  assign cout   = (a[3] & b[3]) | (a[3] & c3) | (b[3] & c3);
endmodule

module rca_seq_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 cin,
  input  logic                 sub,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout,
  output logic                 busy
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic [W-1:0]  a_reg, b_reg, sum_reg;
  logic          carry, cout_reg;

  logic [W-1:0]  a_sh, b_sh;
  logic [3:0]    rca_sum;
  logic          rca_cout;

  // Subtraction is A + ~B + 1: B is inverted at capture and the carry seeded with 1.
  assign a_sh = a_reg >> {idx, 2'b00};
  assign b_sh = b_reg >> {idx, 2'b00};

  rca u_rca (
    .a    (a_sh[3:0]),
    .b    (b_sh[3:0]),
    .cin  (carry),
    .sum  (rca_sum),
    .cout (rca_cout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      carry    <= 1'b0;
      cout_reg <= 1'b0;
      sum_reg  <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= a;
            b_reg <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          for (int i = 0; i < NIBBLES; i++) begin
            if (idx == IW'(i)) sum_reg[4*i +: 4] <= rca_sum;
          end
          carry <= rca_cout;
          if (idx == LAST) begin
            cout_reg <= rca_cout;
            state    <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign sum       = sum_reg;
  assign cout      = cout_reg;
endmodule

// File: tb/tb_rca_seq_adder.sv
// tb/tb_rca_seq_adder.sv - scoreboard bench for rca_seq_adder at NIBBLES = 1, 4 and 8
module tb_rca_seq_adder;
  logic clk;
  logic rst_n;

  logic        v1, rdy1, cin1, sub1, ov1, or1, co1, busy1;
  logic [3:0]  a1, b1, s1;
  logic        v4, rdy4, cin4, sub4, ov4, or4, co4, busy4;
  logic [15:0] a4, b4, s4;
  logic        v8, rdy8, cin8, sub8, ov8, or8, co8, busy8;
  logic [31:0] a8, b8, s8;

  int checks = 0;
  int errors = 0;

  logic [64:0] sb1[$], sb4[$], sb8[$];
  logic [64:0] e1, e4, e8;
  int n1, n4, n8;

  rca_seq_adder #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(rdy1), .a(a1), .b(b1),
    .cin(cin1), .sub(sub1), .out_valid(ov1), .out_ready(or1), .sum(s1), .cout(co1), .busy(busy1));
  rca_seq_adder #(.NIBBLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(rdy4), .a(a4), .b(b4),
    .cin(cin4), .sub(sub4), .out_valid(ov4), .out_ready(or4), .sum(s4), .cout(co4), .busy(busy4));
  rca_seq_adder #(.NIBBLES(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(rdy8), .a(a8), .b(b8),
    .cin(cin8), .sub(sub8), .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(co8), .busy(busy8));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain wide arithmetic; bit 64 carries cout, low bits the masked sum.
  function automatic logic [64:0] model(input int n, input logic [63:0] x, input logic [63:0] y,
                                        input logic c, input logic s);
    logic [64:0] m, r, t;
    m = (65'd1 << (4 * n)) - 65'd1;
    r = ({1'b0, x} & m) + ({1'b0, (s ? ~y : y)} & m) + (s ? 65'd1 : {64'd0, c});
    t = r & m;
    return {r[4*n], t[63:0]};
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      sb1.delete(); sb4.delete(); sb8.delete();
    end else begin
      if (v1 && rdy1) sb1.push_back(model(1, 64'(a1), 64'(b1), cin1, sub1));
      if (v4 && rdy4) sb4.push_back(model(4, 64'(a4), 64'(b4), cin4, sub4));
      if (v8 && rdy8) sb8.push_back(model(8, 64'(a8), 64'(b8), cin8, sub8));
      if (ov1 && or1) begin
        check_val("sb1_nonempty", 65'(sb1.size() != 0), 65'd1);
        if (sb1.size() != 0) begin
          e1 = sb1.pop_front();
          check_val("sb1_sum", 65'(s1), {61'd0, e1[3:0]});
          check_val("sb1_cout", 65'(co1), 65'(e1[64]));
          n1++;
        end
      end
      if (ov4 && or4) begin
        check_val("sb4_nonempty", 65'(sb4.size() != 0), 65'd1);
        if (sb4.size() != 0) begin
          e4 = sb4.pop_front();
          check_val("sb4_sum", 65'(s4), {49'd0, e4[15:0]});
          check_val("sb4_cout", 65'(co4), 65'(e4[64]));
          n4++;
        end
      end
      if (ov8 && or8) begin
        check_val("sb8_nonempty", 65'(sb8.size() != 0), 65'd1);
        if (sb8.size() != 0) begin
          e8 = sb8.pop_front();
          check_val("sb8_sum", 65'(s8), {33'd0, e8[31:0]});
          check_val("sb8_cout", 65'(co8), 65'(e8[64]));
          n8++;
        end
      end
    end
  end

  // Waits for out_valid on dut4; lat counts edges after the accept edge.
  task automatic wait_valid4(output int lat, output int busy_bad);
    lat = 0;
    busy_bad = 0;
    while (!ov4 && lat < 50) begin
      if (!busy4) busy_bad++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic op4(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                     input logic tcin, input logic tsub, input logic [15:0] esum, input logic ecout);
    int lat, busy_bad;
    @(posedge clk); #1;
    a4 = ta; b4 = tb; cin4 = tcin; sub4 = tsub; v4 = 1'b1; or4 = 1'b1;
    @(negedge clk);
    check_val({tag, "_in_ready"}, 65'(rdy4), 65'd1);
    @(posedge clk); #1;
    v4 = 1'b0;
    a4 = 16'($urandom); b4 = 16'($urandom); cin4 = ~cin4; sub4 = ~sub4;
    wait_valid4(lat, busy_bad);
    check_val({tag, "_latency"}, 65'(lat), 65'd4);
    check_val({tag, "_sum"}, 65'(s4), 65'(esum));
    check_val({tag, "_cout"}, 65'(co4), 65'(ecout));
    check_val({tag, "_busy_run"}, 65'(busy_bad), 65'd0);
    check_val({tag, "_busy_done"}, 65'(busy4), 65'd1);
    @(posedge clk); #1;
    check_val({tag, "_idle_busy"}, 65'(busy4), 65'd0);
    check_val({tag, "_idle_ov"}, 65'(ov4), 65'd0);
  endtask

  task automatic op1(input logic [3:0] ta, input logic [3:0] tb, input logic [3:0] esum, input logic ecout);
    int lat;
    @(posedge clk); #1;
    a1 = ta; b1 = tb; cin1 = 1'b0; sub1 = 1'b0; v1 = 1'b1; or1 = 1'b1;
    @(posedge clk); #1;
    v1 = 1'b0;
    lat = 0;
    while (!ov1 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check_val("n1_latency", 65'(lat), 65'd1);
    check_val("n1_sum", 65'(s1), 65'(esum));
    check_val("n1_cout", 65'(co1), 65'(ecout));
    @(posedge clk); #1;
  endtask

  task automatic op8(input logic [31:0] ta, input logic [31:0] tb, input logic [31:0] esum, input logic ecout);
    int lat;
    @(posedge clk); #1;
    a8 = ta; b8 = tb; cin8 = 1'b0; sub8 = 1'b0; v8 = 1'b1; or8 = 1'b1;
    @(posedge clk); #1;
    v8 = 1'b0;
    lat = 0;
    while (!ov8 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check_val("n8_latency", 65'(lat), 65'd8);
    check_val("n8_sum", 65'(s8), 65'(esum));
    check_val("n8_cout", 65'(co8), 65'(ecout));
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, busy_bad;
    rst_n = 1'b0;
    v1 = 0; a1 = 0; b1 = 0; cin1 = 0; sub1 = 0; or1 = 0;
    v4 = 0; a4 = 0; b4 = 0; cin4 = 0; sub4 = 0; or4 = 0;
    v8 = 0; a8 = 0; b8 = 0; cin8 = 0; sub8 = 0; or8 = 0;
    n1 = 0; n4 = 0; n8 = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    check_val("rst_in_ready", 65'(rdy4), 65'd1);
    check_val("rst_out_valid", 65'(ov4), 65'd0);
    check_val("rst_sum", 65'(s4), 65'd0);
    check_val("rst_cout", 65'(co4), 65'd0);
    check_val("rst_busy", 65'(busy4), 65'd0);
    check_val("rst_n1_ready", 65'(rdy1), 65'd1);
    check_val("rst_n8_valid", 65'(ov8), 65'd0);

    op4("add_nc",   16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0);
    op4("ripple",   16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1);
    op4("sub_a",    16'h1000, 16'h0001, 1'b0, 1'b1, 16'h0FFF, 1'b1);
    op4("sub_b",    16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0);
    op4("sub_cin",  16'h1000, 16'h0001, 1'b1, 1'b1, 16'h0FFF, 1'b1);
    op4("add_cin",  16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0);

    // Backpressure: result must hold while a new request waits outside.
    @(posedge clk); #1;
    a4 = 16'h1111; b4 = 16'h2222; cin4 = 0; sub4 = 0; v4 = 1'b1; or4 = 1'b0;
    @(posedge clk); #1;
    v4 = 1'b0;
    wait_valid4(lat, busy_bad);
    check_val("bp_latency", 65'(lat), 65'd4);
    for (int i = 0; i < 6; i++) begin
      a4 = 16'($urandom); b4 = 16'($urandom); cin4 = 1'($urandom); sub4 = 1'($urandom); v4 = 1'b1;
      @(posedge clk); #1;
      check_val("bp_sum", 65'(s4), 65'h3333);
      check_val("bp_cout", 65'(co4), 65'd0);
      check_val("bp_in_ready", 65'(rdy4), 65'd0);
      check_val("bp_out_valid", 65'(ov4), 65'd1);
    end
    or4 = 1'b1;
    @(posedge clk); #1;
    check_val("bp_back_idle", 65'(rdy4), 65'd1);
    a4 = 16'h00AA; b4 = 16'h0055; cin4 = 0; sub4 = 0;
    @(posedge clk); #1;
    check_val("bp_accepted", 65'(busy4), 65'd1);
    v4 = 1'b0;
    wait_valid4(lat, busy_bad);
    check_val("bp2_latency", 65'(lat), 65'd4);
    check_val("bp2_sum", 65'(s4), 65'h00FF);
    @(posedge clk); #1;

    // Reset while idx == 2: the operation must vanish without output.
    a4 = 16'h5678; b4 = 16'h1111; cin4 = 0; sub4 = 0; v4 = 1'b1;
    @(posedge clk); #1;
    v4 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_val("mid_rst_ready", 65'(rdy4), 65'd1);
    check_val("mid_rst_ov", 65'(ov4), 65'd0);
    check_val("mid_rst_sum", 65'(s4), 65'd0);
    check_val("mid_rst_busy", 65'(busy4), 65'd0);
    op4("post_rst", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0);

    op1(4'hF, 4'h1, 4'h0, 1'b1);
    op8(32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1);

    // Back-to-back random traffic on all three widths with out_ready held high.
    n1 = 0; n4 = 0; n8 = 0;
    fork
      begin
        for (int c = 0; c < 20000 && n1 < 1000; c++) begin
          a1 = 4'($urandom); b1 = 4'($urandom); cin1 = 1'($urandom); sub1 = 1'($urandom);
          v1 = 1'b1; or1 = 1'b1;
          @(posedge clk); #1;
        end
        v1 = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check_val("rand1_count", 65'(n1 >= 1000), 65'd1);
        check_val("rand1_drain", 65'(sb1.size()), 65'd0);
      end
      begin
        for (int c = 0; c < 20000 && n4 < 1000; c++) begin
          a4 = 16'($urandom); b4 = 16'($urandom); cin4 = 1'($urandom); sub4 = 1'($urandom);
          v4 = 1'b1; or4 = 1'b1;
          @(posedge clk); #1;
        end
        v4 = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check_val("rand4_count", 65'(n4 >= 1000), 65'd1);
        check_val("rand4_drain", 65'(sb4.size()), 65'd0);
      end
      begin
        for (int c = 0; c < 20000 && n8 < 1000; c++) begin
          a8 = $urandom; b8 = $urandom; cin8 = 1'($urandom); sub8 = 1'($urandom);
          v8 = 1'b1; or8 = 1'b1;
          @(posedge clk); #1;
        end
        v8 = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check_val("rand8_count", 65'(n8 >= 1000), 65'd1);
        check_val("rand8_drain", 65'(sb8.size()), 65'd0);
      end
    join

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
